// File: rtl/dmem_arbiter_pkg.sv
// Shared types and width constants for the data-memory arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).

`ifndef DMARB_DEFINES_SV
`define DMARB_DEFINES_SV
`ifndef DATAWIDTH
`define DATAWIDTH 32
`endif
`ifndef DM_ADDR_WIDTH
`define DM_ADDR_WIDTH 10
`endif
`ifndef DMARB_TAG_W
`define DMARB_TAG_W 2
`endif
`endif

package dmem_arbiter_pkg;

    localparam int DMARB_DATA_W = `DATAWIDTH;
    localparam int DMARB_ADDR_W = `DM_ADDR_WIDTH;
    localparam int DMARB_TAG_W  = `DMARB_TAG_W;

    // Requester id carried with each in-flight read; the tag is {valid, port}
    typedef enum logic [DMARB_TAG_W-2:0] {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    typedef struct packed {
        logic  vld;
        port_e port;
    } rd_tag_t;

    // Port-1 starvation counter: clears when port 1 is served or idle,
    // otherwise counts denied cycles and sticks at the forcing threshold.
    function automatic logic [3:0] wait_next(input logic [3:0] cnt,
                                             input logic       req,
                                             input logic       gnt,
                                             input logic [3:0] max_wait);
        if (!req || gnt) begin
            return 4'd0;
        end
        if (cnt >= max_wait) begin
            return max_wait;
        end
        return cnt + 4'd1;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rd_tag_pipe.sv
// Read-tag delay line: carries {valid, port} alongside the memory read.
// Latency: DEPTH cycles from tag_i to tag_o.
// Backpressure: none; shifts every cycle, cleared asynchronously by reset.

module dmarb_rd_tag_pipe
    import dmem_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  rd_tag_t tag_i,
    output rd_tag_t tag_o
);

    rd_tag_t stage_q [DEPTH];

    // Shift tags one stage per cycle; reset drops every in-flight read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter onto a single-port data memory, port 0 fixed priority.
// Latency: grant T -> mem command T+1 -> read data valid T+2+RD_LAT.
// Backpressure: combinational gnt; port 1 forced through after MAX_WAIT denials.

module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DATA_W   = DMARB_DATA_W,
    parameter int ADDR_W   = DMARB_ADDR_W,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req_i,
    input  logic              p0_we_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [DATA_W-1:0] p0_wdata_i,
    output logic              p0_gnt_o,
    output logic              p0_rvalid_o,
    output logic [DATA_W-1:0] p0_rdata_o,
    input  logic              p1_req_i,
    input  logic              p1_we_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [DATA_W-1:0] p1_wdata_i,
    output logic              p1_gnt_o,
    output logic              p1_rvalid_o,
    output logic [DATA_W-1:0] p1_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic              force1, gnt0, gnt1, acc_vld, acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              mem_en_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              p0_rvalid_q, p1_rvalid_q;
    logic [DATA_W-1:0] p0_rdata_q, p1_rdata_q;
    rd_tag_t           tag_in, tag_out;

    // Grants are masked during reset so every output reads zero while rst is high
    assign force1   = (wait_cnt_q == MAX_WAIT_C);
    assign gnt1     = ~rst & p1_req_i & (~p0_req_i | force1);
    assign gnt0     = ~rst & p0_req_i & ~gnt1;
    assign acc_vld  = gnt0 | gnt1;
    assign acc_we   = gnt1 ? p1_we_i    : p0_we_i;
    assign acc_addr = gnt1 ? p1_addr_i  : p0_addr_i;
    assign acc_wdata= gnt1 ? p1_wdata_i : p0_wdata_i;
    assign wait_cnt_d = wait_next(wait_cnt_q, p1_req_i, gnt1, MAX_WAIT_C);

    // Count port-1 denied cycles to bound its wait behind port 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= 4'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Register the accepted command; address/data hold when idle to avoid toggling
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_en_q <= acc_vld;
            mem_we_q <= acc_vld & acc_we;
            if (acc_vld) begin
                mem_addr_q  <= acc_addr;
                mem_wdata_q <= acc_wdata;
            end
        end
    end

    // Tag follows the read through the command register and the memory latency
    assign tag_in = '{vld: acc_vld & ~acc_we, port: (gnt1 ? PORT1 : PORT0)};

    dmarb_rd_tag_pipe #(
        .DEPTH (RD_LAT + 1)
    ) u_tag_pipe (
        .clk   (clk),
        .rst   (rst),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    // Steer returning read data to the issuing port; the other port keeps its data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
        end else begin
            p0_rvalid_q <= tag_out.vld && (tag_out.port == PORT0);
            p1_rvalid_q <= tag_out.vld && (tag_out.port == PORT1);
            if (tag_out.vld && (tag_out.port == PORT0)) begin
                p0_rdata_q <= mem_rdata_i;
            end
            if (tag_out.vld && (tag_out.port == PORT1)) begin
                p1_rdata_q <= mem_rdata_i;
            end
        end
    end

    assign p0_gnt_o    = gnt0;
    assign p1_gnt_o    = gnt1;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign p0_rvalid_o = p0_rvalid_q;
    assign p1_rvalid_o = p1_rvalid_q;
    assign p0_rdata_o  = p0_rdata_q;
    assign p1_rdata_o  = p1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench: two arbiters (RD_LAT=1 and RD_LAT=3) driven by the same requests.
// Each has its own memory model; a transaction-level reference predicts every output.
// Directed scenarios pin literal values, then a randomized phase runs against the model.

module tb_dmem_arbiter;

    localparam int MAXW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
    logic [9:0]  p0_addr = '0, p1_addr = '0;
    logic [31:0] p0_wdata = '0, p1_wdata = '0;

    logic [1:0]  g0, g1, rv0, rv1, men, mwe;
    logic [31:0] rd0 [2];
    logic [31:0] rd1 [2];
    logic [9:0]  maddr [2];
    logic [31:0] mwd [2];
    logic [31:0] mrd [2];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_arbiter #(.DATA_W(32), .ADDR_W(10), .RD_LAT(1), .MAX_WAIT(MAXW)) u_dut0 (
        .clk(clk), .rst(rst),
        .p0_req_i(p0_req), .p0_we_i(p0_we), .p0_addr_i(p0_addr), .p0_wdata_i(p0_wdata),
        .p0_gnt_o(g0[0]), .p0_rvalid_o(rv0[0]), .p0_rdata_o(rd0[0]),
        .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata),
        .p1_gnt_o(g1[0]), .p1_rvalid_o(rv1[0]), .p1_rdata_o(rd1[0]),
        .mem_en_o(men[0]), .mem_we_o(mwe[0]), .mem_addr_o(maddr[0]), .mem_wdata_o(mwd[0]),
        .mem_rdata_i(mrd[0]));

    dmem_arbiter #(.DATA_W(32), .ADDR_W(10), .RD_LAT(3), .MAX_WAIT(MAXW)) u_dut1 (
        .clk(clk), .rst(rst),
        .p0_req_i(p0_req), .p0_we_i(p0_we), .p0_addr_i(p0_addr), .p0_wdata_i(p0_wdata),
        .p0_gnt_o(g0[1]), .p0_rvalid_o(rv0[1]), .p0_rdata_o(rd0[1]),
        .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata),
        .p1_gnt_o(g1[1]), .p1_rvalid_o(rv1[1]), .p1_rdata_o(rd1[1]),
        .mem_en_o(men[1]), .mem_we_o(mwe[1]), .mem_addr_o(maddr[1]), .mem_wdata_o(mwd[1]),
        .mem_rdata_i(mrd[1]));

    // Single-port memories: reset image is addr + 0x100, read latency 1 and 3
    logic [31:0] mem   [2][1024];
    logic [31:0] rpipe [2][3];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                for (int a = 0; a < 1024; a++) mem[i][a] <= 32'(a) + 32'h100;
            end else if (men[i]) begin
                if (mwe[i]) mem[i][maddr[i]] <= mwd[i];
                rpipe[i][0] <= mem[i][maddr[i]];
            end
            rpipe[i][1] <= rpipe[i][0];
            rpipe[i][2] <= rpipe[i][1];
        end
    end
    assign mrd[0] = rpipe[0][0];
    assign mrd[1] = rpipe[1][2];

    task automatic chk1(input string name, input int inst, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[dut%0d] cycle %0d: got %b, expected %b", name, inst, cyc, act, exp);
        end
    endtask

    task automatic chk32(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[dut%0d] cycle %0d: got %h, expected %h", name, inst, cyc, act, exp);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    typedef struct {
        int          inst;
        int          due;
        bit          port;
        logic [31:0] data;
    } resp_t;

    resp_t       rq [$];
    resp_t       keep [$];
    int          wcnt [2];
    logic        exp_en [2];
    logic        exp_we [2];
    logic [9:0]  exp_addr [2];
    logic [31:0] exp_wd [2];
    logic [31:0] exp_rd [2][2];
    logic [31:0] mmem [2][1024];

    task automatic model_reset();
        rq = {};
        for (int i = 0; i < 2; i++) begin
            wcnt[i] = 0; exp_en[i] = 1'b0; exp_we[i] = 1'b0;
            exp_addr[i] = '0; exp_wd[i] = '0; exp_rd[i][0] = '0; exp_rd[i][1] = '0;
            for (int a = 0; a < 1024; a++) mmem[i][a] = 32'(a) + 32'h100;
        end
    endtask

    // Compare every cycle, then advance the model with this cycle's requests
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                chk1("rst_p0_gnt", i, g0[i], 1'b0);   chk1("rst_p1_gnt", i, g1[i], 1'b0);
                chk1("rst_mem_en", i, men[i], 1'b0);  chk1("rst_mem_we", i, mwe[i], 1'b0);
                chk1("rst_p0_rvalid", i, rv0[i], 1'b0); chk1("rst_p1_rvalid", i, rv1[i], 1'b0);
            end
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++) begin
                int   lat;
                logic eg0, eg1, ev0, ev1, we;
                logic [9:0] a;
                logic [31:0] d;
                lat = (i == 0) ? 1 : 3;
                eg1 = p1_req && (!p0_req || (wcnt[i] == MAXW));
                eg0 = p0_req && !eg1;
                chk1("p0_gnt", i, g0[i], eg0);
                chk1("p1_gnt", i, g1[i], eg1);
                chk1("mem_en", i, men[i], exp_en[i]);
                chk1("mem_we", i, mwe[i], exp_we[i]);
                chk32("mem_addr", i, {22'b0, maddr[i]}, {22'b0, exp_addr[i]});
                chk32("mem_wdata", i, mwd[i], exp_wd[i]);
                ev0 = 1'b0; ev1 = 1'b0;
                foreach (rq[k]) begin
                    if (rq[k].inst == i && rq[k].due == cyc) begin
                        if (rq[k].port) begin ev1 = 1'b1; exp_rd[i][1] = rq[k].data; end
                        else            begin ev0 = 1'b1; exp_rd[i][0] = rq[k].data; end
                    end
                end
                chk1("p0_rvalid", i, rv0[i], ev0);
                chk1("p1_rvalid", i, rv1[i], ev1);
                chk32("p0_rdata", i, rd0[i], exp_rd[i][0]);
                chk32("p1_rdata", i, rd1[i], exp_rd[i][1]);
                if (!p1_req || eg1) wcnt[i] = 0;
                else if (wcnt[i] < MAXW) wcnt[i] = wcnt[i] + 1;
                if (eg0 || eg1) begin
                    we = eg1 ? p1_we : p0_we;
                    a  = eg1 ? p1_addr : p0_addr;
                    d  = eg1 ? p1_wdata : p0_wdata;
                    exp_en[i] = 1'b1; exp_we[i] = we; exp_addr[i] = a; exp_wd[i] = d;
                    if (we) mmem[i][a] = d;
                    else rq.push_back('{i, cyc + 2 + lat, eg1, mmem[i][a]});
                end else begin
                    exp_en[i] = 1'b0; exp_we[i] = 1'b0;
                end
            end
            chk1("wait_cnt_bound", 0, (u_dut0.wait_cnt_q <= 4'd4), 1'b1);
            keep = {};
            foreach (rq[k]) if (rq[k].due > cyc) keep.push_back(rq[k]);
            rq = keep;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        p0_req = 1'b0; p1_req = 1'b0; p0_we = 1'b0; p1_we = 1'b0;
        repeat (n) step();
    endtask

    logic [9:0] gbits;
    logic       lg0, lg1;

    initial begin
        rst = 1'b1;
        repeat (3) step();
        for (int i = 0; i < 2; i++) begin
            chk32("init_mem_addr", i, {22'b0, maddr[i]}, 32'h0);
            chk32("init_p0_rdata", i, rd0[i], 32'h0);
            chk32("init_p1_rdata", i, rd1[i], 32'h0);
        end
        rst = 1'b0;
        idle(2);

        // Port 0 only: write then read 0x010
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 10'h010; p0_wdata = 32'hDEADBEEF;
        @(negedge clk); chk1("t1_wr_gnt", 0, g0[0], 1'b1);
        step(); p0_we = 1'b0; p0_wdata = 32'h0;
        @(negedge clk); chk1("t1_rd_gnt", 0, g0[0], 1'b1); chk1("t1_we_wr", 0, mwe[0], 1'b1);
        step(); p0_req = 1'b0;
        @(negedge clk); chk1("t1_we_rd", 0, mwe[0], 1'b0); chk1("t1_en_rd", 0, men[0], 1'b1);
        step(); @(negedge clk); chk1("t1_rv_early", 0, rv0[0], 1'b0);
        step(); @(negedge clk); chk1("t1_rv", 0, rv0[0], 1'b1); chk32("t1_rdata", 0, rd0[0], 32'hDEADBEEF);
        step(); step();
        @(negedge clk); chk1("t1_rv_lat3", 1, rv0[1], 1'b1); chk32("t1_rdata_lat3", 1, rd0[1], 32'hDEADBEEF);
        idle(4);

        // Both ports continuously: p0 x4, p1 x1
        for (int k = 0; k < 10; k++) begin
            p0_req = 1'b1; p0_we = 1'b0; p0_addr = 10'h003;
            p1_req = 1'b1; p1_we = 1'b0; p1_addr = 10'h002;
            @(negedge clk); gbits[k] = g1[0];
            step();
        end
        chk32("t2_p1_grant_pattern", 0, {22'b0, gbits}, 32'h210);
        idle(8);

        // Interleaved reads 0x001 (p0) then 0x002 (p1)
        p0_req = 1'b1; p0_addr = 10'h001;
        @(negedge clk); chk1("t3_p0_gnt", 0, g0[0], 1'b1);
        step(); p0_req = 1'b0; p1_req = 1'b1; p1_addr = 10'h002;
        @(negedge clk); chk1("t3_p1_gnt", 0, g1[0], 1'b1);
        step(); p1_req = 1'b0;
        step();
        @(negedge clk); chk1("t3_p0_rv", 0, rv0[0], 1'b1); chk1("t3_p1_quiet", 0, rv1[0], 1'b0);
        chk32("t3_p0_rdata", 0, rd0[0], 32'h101);
        step();
        @(negedge clk); chk1("t3_p1_rv", 0, rv1[0], 1'b1); chk1("t3_p0_quiet", 0, rv0[0], 1'b0);
        chk32("t3_p1_rdata", 0, rd1[0], 32'h102); chk32("t3_p0_hold", 0, rd0[0], 32'h101);
        idle(8);

        // Back-to-back reads 0..7, checked on the RD_LAT=3 instance
        for (int t = 0; t < 13; t++) begin
            if (t < 8) begin p0_req = 1'b1; p0_we = 1'b0; p0_addr = 10'(t); end
            else p0_req = 1'b0;
            @(negedge clk);
            if (t == 4) chk1("t4_rv_early", 1, rv0[1], 1'b0);
            if (t >= 5) begin
                chk1("t4_rv", 1, rv0[1], 1'b1);
                chk32("t4_rdata", 1, rd0[1], 32'h100 + 32'(t - 5));
            end
            step();
        end
        idle(6);

        // Reset with two reads in flight
        p0_req = 1'b1; p0_addr = 10'h004; step();
        p0_addr = 10'h005; step();
        p0_req = 1'b0;
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk1("t5_async_en", i, men[i], 1'b0);
            chk1("t5_async_rv0", i, rv0[i], 1'b0);
            chk32("t5_async_addr", i, {22'b0, maddr[i]}, 32'h0);
            chk32("t5_async_rd0", i, rd0[i], 32'h0);
        end
        step(); step();
        #2 rst = 1'b0;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                chk1("t5_no_rv0", i, rv0[i], 1'b0);
                chk1("t5_no_rv1", i, rv1[i], 1'b0);
            end
        end
        step(); idle(2);

        // p1 withdrawn after 2 denials: forced grant only after 4 fresh denials
        for (int t = 0; t < 8; t++) begin
            p0_req = 1'b1; p0_we = 1'b0; p0_addr = 10'h006;
            p1_req = (t != 2); p1_we = 1'b0; p1_addr = 10'h007;
            @(negedge clk); gbits[t] = g1[0];
            step();
        end
        chk32("t6_p1_grant_pattern", 0, {24'b0, gbits[7:0]}, 32'h80);
        idle(8);

        // Randomized traffic; requests hold address/data until granted
        lg0 = 1'b1; lg1 = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if (!(p0_req && !lg0)) begin
                p0_req = ($urandom_range(0, 3) != 0); p0_we = $urandom_range(0, 1) == 1;
                p0_addr = 10'($urandom_range(0, 15)); p0_wdata = $urandom;
            end else if ($urandom_range(0, 7) == 0) p0_req = 1'b0;
            if (!(p1_req && !lg1)) begin
                p1_req = ($urandom_range(0, 2) != 0); p1_we = $urandom_range(0, 1) == 1;
                p1_addr = 10'($urandom_range(0, 15)); p1_wdata = $urandom;
            end else if ($urandom_range(0, 15) == 0) p1_req = 1'b0;
            @(negedge clk); lg0 = g0[0]; lg1 = g1[0];
            step();
        end
        idle(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory between two requesters: port 0 is the core load/store path, fed by the registered effective-address/store-data stage; port 1 is the external program/data loader and debug port. The block accepts one access per cycle, registers the chosen command onto the memory bus, and routes read data back to the requester that issued it. Port 0 has fixed priority, and a wait counter guarantees port 1 forward progress. It sits between the address-calculation stage and the data BRAM.

## Interface
Parameters:
- DATA_W, default `datawidth (32): data width.
- ADDR_W, default `dm_addr_width (10): word address width.
- RD_LAT, default 1, legal 1..3: memory read latency, from mem_en_o sampled to mem_rdata_i valid.
- MAX_WAIT, default 4, legal 1..15: port-1 denied cycles before it gets forced priority.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- p0_req_i, p1_req_i  in  1  access request; address and data must be held stable until granted.
- p0_we_i, p1_we_i  in  1  1 = write, 0 = read.
- p0_addr_i, p1_addr_i  in  ADDR_W  word address.
- p0_wdata_i, p1_wdata_i  in  DATA_W  store data.
- p0_gnt_o, p1_gnt_o  out  1  combinational accept; a transfer occurs when req and gnt are both high.
- p0_rvalid_o, p1_rvalid_o  out  1  read data valid, one-cycle pulse.
- p0_rdata_o, p1_rdata_o  out  DATA_W  read data, registered.
- mem_en_o, mem_we_o  out  1  registered memory enable and write enable.
- mem_addr_o  out  ADDR_W  registered memory address.
- mem_wdata_o  out  DATA_W  registered memory write data.
- mem_rdata_i  in  DATA_W  memory read data.

## Operation
- Grant rule, evaluated each cycle:
  - p1_gnt_o = p1_req_i & (~p0_req_i | force1).
  - p0_gnt_o = p0_req_i & ~p1_gnt_o.
  - force1 = (wait_cnt == MAX_WAIT).
  - At most one grant per cycle.
- wait_cnt (4 bits): increments when p1_req_i & ~p1_gnt_o. Clears on p1 grant or when p1_req_i is low. Saturates at MAX_WAIT.
- Accepted command is registered: the next cycle drives mem_en_o=1 with we/addr/wdata from the granted port. With no grant, mem_en_o=0; addr/wdata hold their previous values; mem_we_o=0.
- Read tag pipeline: a {valid, port} tag enters when a read is accepted. It shifts RD_LAT+1 stages. At the output it captures mem_rdata_i into the tagged port's rdata register and pulses that port's rvalid.
- Writes produce no response.
- Requests are serviced in grant order, so a write followed by a read to the same address returns the written data.
- rdata_o of the port that was not selected holds its value.

## Timing
- Reset values: all gnt/rvalid/mem_en/mem_we = 0; mem_addr, mem_wdata, p*_rdata = 0; wait_cnt = 0; tag pipeline cleared.
- Grant cycle T → mem_en_o high at T+1 → p*_rvalid_o high at T+2+RD_LAT (T+3 at default).
- Throughput: one access per cycle, with back-to-back mixed reads and writes across both ports.
- Reset asserted mid-operation: in-flight read tags are discarded, and no rvalid is emitted for them after reset releases.
- Simultaneous requests with wait_cnt < MAX_WAIT: port 0 wins.
- At wait_cnt == MAX_WAIT: port 1 wins and wait_cnt clears the same edge.
- Request dropped without a grant: legal, no side effect.
- Request held after a grant: it is treated as a new access.

## Structure
- Width macros stay in defines.v (`datawidth, `dm_addr_width).
- Add `dmarb_tag_w (2: valid + port id) to defines.v.
- One sub-module, dmarb_rd_tag_pipe: a parameterised RD_LAT+1-deep shift register of tags with asynchronous clear.
- Grant logic, wait counter and command register stay in dmem_arbiter.

## Test plan
- Port-0 only: write 0xDEADBEEF to 0x010, then read 0x010. Expected: p0_gnt_o=1 both cycles, mem_we_o=1 then 0, p0_rvalid_o 3 cycles after the read grant with data 0xDEADBEEF, p1_rvalid_o never asserted.
- Port 0 and port 1 requesting continuously, MAX_WAIT=4. Expected: grant pattern p0×4, p1×1, repeating; wait_cnt never exceeds 4.
- Interleaved reads: p0 reads 0x001 and p1 reads 0x002 on consecutive grants, memory model returns addr+0x100. Expected: p0 gets 0x101 and p1 gets 0x102, each on the correct port and cycle, with no cross-routing.
- RD_LAT=3: back-to-back reads to 0x000..0x007. Expected: 8 consecutive rvalid pulses in order, first at grant+5.
- Assert rst while two reads are in flight. Expected: all outputs 0 immediately (asynchronous), no rvalid in the 5 cycles after release.
- p1 request withdrawn after 2 denied cycles, then reasserted. Expected: wait_cnt restarts from 0, so the forced grant arrives only after 4 more denied cycles.
